bram_reinit_ctrl: RTL and testbench

- Owns the single port of one `DWID`x`2^AWID` block RAM, which has a 1-cycle registered read and read-during-write returning old data.
- Shares that port between a user requester and a reinit engine. The engine rewrites a contiguous address window from a byte stream, which is how memory contents are refreshed without a full reconfiguration.
- Sits directly in front of the RAM instance; the RAM's `clk` is shared.

---
 rtl/bram_reinit_pkg.sv | 14 +
 rtl/bram_reinit_ctrl_if.sv | 56 +++++
 rtl/bram_reinit_addr_gen.sv | 49 ++++
 rtl/bram_reinit_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bram_reinit_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_reinit_pkg.sv
// Shared types and default widths for the BRAM reinit controller slice.
package bram_reinit_pkg;

  localparam int DEF_DWID = 8;
  localparam int DEF_AWID = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } reinit_state_t;

endpackage

// File: rtl/bram_reinit_ctrl_if.sv
// User port, reinit stream, status and RAM-side signals of bram_reinit_ctrl.
// verify_err exists only when BRAM_REINIT_VERIFY_EN is defined.
interface bram_reinit_ctrl_if
  import bram_reinit_pkg::*;
#(
  parameter int DWID = DEF_DWID,
  parameter int AWID = DEF_AWID
);

  logic            u_req;
  logic            u_wen;
  logic [AWID-1:0] u_addr;
  logic [DWID-1:0] u_din;
  logic            u_gnt;
  logic            u_rvalid;
  logic [DWID-1:0] u_dout;
  logic            ri_start;
  logic [AWID-1:0] ri_base;
  logic [AWID-1:0] ri_len;
  logic            ri_valid;
  logic [DWID-1:0] ri_data;
  logic            ri_ready;
  logic            ri_abort;
  logic            busy;
  logic            done;
  logic [AWID-1:0] ram_addr;
  logic [DWID-1:0] ram_din;
  logic            ram_wen;
  logic [DWID-1:0] ram_dout;
`ifdef BRAM_REINIT_VERIFY_EN
  logic            verify_err;
`endif

  modport slave (
    input  u_req, u_wen, u_addr, u_din,
    input  ri_start, ri_base, ri_len, ri_valid, ri_data, ri_abort,
    input  ram_dout,
    output u_gnt, u_rvalid, u_dout, ri_ready, busy, done,
    output ram_addr, ram_din, ram_wen
`ifdef BRAM_REINIT_VERIFY_EN
    , output verify_err
`endif
  );

  modport master (
    output u_req, u_wen, u_addr, u_din,
    output ri_start, ri_base, ri_len, ri_valid, ri_data, ri_abort,
    output ram_dout,
    input  u_gnt, u_rvalid, u_dout, ri_ready, busy, done,
    input  ram_addr, ram_din, ram_wen
`ifdef BRAM_REINIT_VERIFY_EN
    , input verify_err
`endif
  );

endinterface

// File: rtl/bram_reinit_addr_gen.sv
// Window address generator: latched base plus beat counter, wrapping modulo 2^AWID.
// at_end is only needed by the read-back pass (BRAM_REINIT_VERIFY_EN).
module bram_reinit_addr_gen
  import bram_reinit_pkg::*;
#(
  parameter int AWID = DEF_AWID
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clr,
  input  logic            inc,
  input  logic [AWID-1:0] base_in,
  input  logic [AWID-1:0] len_in,
  output logic [AWID-1:0] addr,
  output logic            last
`ifdef BRAM_REINIT_VERIFY_EN
  , output logic          at_end
`endif
);

  logic [AWID-1:0] base_r;
  logic [AWID:0]   len_r;
  logic [AWID:0]   cnt_r;

  // Latch window on load (len 0 means full 2^AWID); clear or advance the beat count
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= '0;
      len_r  <= '0;
      cnt_r  <= '0;
    end else if (load) begin
      base_r <= base_in;
      len_r  <= (len_in == '0) ? {1'b1, {AWID{1'b0}}} : {1'b0, len_in};
      cnt_r  <= '0;
    end else if (clr) begin
      cnt_r  <= '0;
    end else if (inc) begin
      cnt_r  <= cnt_r + {{AWID{1'b0}}, 1'b1};
    end
  end

  assign addr = base_r + cnt_r[AWID-1:0];
  assign last = ((cnt_r + {{AWID{1'b0}}, 1'b1}) == len_r);
`ifdef BRAM_REINIT_VERIFY_EN
  assign at_end = (cnt_r == len_r);
`endif

endmodule

// File: rtl/bram_reinit_ctrl.sv
// Single-port BRAM front end arbitrating between a user port and a window reinit engine.
// Optional read-back checksum pass enabled by BRAM_REINIT_VERIFY_EN.
module bram_reinit_ctrl
  import bram_reinit_pkg::*;
#(
  parameter int DWID = DEF_DWID,
  parameter int AWID = DEF_AWID
) (
  input logic               clk,
  input logic               rst,
  bram_reinit_ctrl_if.slave bus
);

  reinit_state_t   state_r;
  reinit_state_t   state_nxt_s;
  logic            u_ok_s;
  logic            fill_wr_s;
  logic            ag_load_s;
  logic            ag_clr_s;
  logic            ag_inc_s;
  logic            ag_last_s;
  logic [AWID-1:0] ag_addr_s;
  logic            rvalid_r;
`ifdef BRAM_REINIT_VERIFY_EN
  logic                 ag_end_s;
  logic                 vrd_s;
  logic                 rd_pend_r;
  logic                 verr_r;
  logic                 cmp_s;
  logic [DWID+AWID-1:0] wsum_r;
  logic [DWID+AWID-1:0] rsum_r;
`endif

  bram_reinit_addr_gen #(.AWID(AWID)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (ag_load_s),
    .clr     (ag_clr_s),
    .inc     (ag_inc_s),
    .base_in (bus.ri_base),
    .len_in  (bus.ri_len),
    .addr    (ag_addr_s),
    .last    (ag_last_s)
`ifdef BRAM_REINIT_VERIFY_EN
    , .at_end (ag_end_s)
`endif
  );

  // Next-state and port-ownership decode
  always_comb begin
    state_nxt_s = state_r;
    u_ok_s      = 1'b0;
    fill_wr_s   = 1'b0;
    ag_load_s   = 1'b0;
    ag_clr_s    = 1'b0;
    ag_inc_s    = 1'b0;
`ifdef BRAM_REINIT_VERIFY_EN
    vrd_s       = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        // reinit start wins over a same-cycle user request
        if (bus.ri_start) begin
          state_nxt_s = ST_FILL;
          ag_load_s   = 1'b1;
        end else begin
          u_ok_s = bus.u_req;
        end
      end
      ST_FILL: begin
        if (bus.ri_abort) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.ri_valid) begin
          fill_wr_s = 1'b1;
          ag_inc_s  = 1'b1;
          if (ag_last_s) begin
`ifdef BRAM_REINIT_VERIFY_EN
            state_nxt_s = ST_VERIFY;
            ag_clr_s    = 1'b1;
`else
            state_nxt_s = ST_DONE;
`endif
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_VERIFY: begin
`ifdef BRAM_REINIT_VERIFY_EN
        if (bus.ri_abort) begin
          state_nxt_s = ST_IDLE;
        end else if (!ag_end_s) begin
          vrd_s    = 1'b1;
          ag_inc_s = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and user read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rvalid_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rvalid_r <= u_ok_s & ~bus.u_wen;
    end
  end

  // RAM-facing strobes are suppressed while rst is high so nothing is written then
  assign bus.u_gnt    = u_ok_s & ~rst;
  assign bus.ram_wen  = ~rst & ((u_ok_s & bus.u_wen) | fill_wr_s);
  assign bus.ram_addr = rst ? '0 : ((state_r == ST_IDLE) ? bus.u_addr : ag_addr_s);
  assign bus.ram_din  = rst ? '0 : ((state_r == ST_IDLE) ? bus.u_din : bus.ri_data);
  assign bus.ri_ready = (state_r == ST_FILL) & ~bus.ri_abort & ~rst;
  assign bus.busy     = (state_r != ST_IDLE);
  assign bus.done     = (state_r == ST_DONE);
  assign bus.u_rvalid = rvalid_r;
  assign bus.u_dout   = rvalid_r ? bus.ram_dout : '0;

`ifdef BRAM_REINIT_VERIFY_EN
  // the last read-back word arrives in the final VERIFY cycle, so fold it in directly
  assign cmp_s = (state_r == ST_VERIFY) & ~bus.ri_abort & ag_end_s;

  // Write/read-back checksums and the sticky mismatch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wsum_r    <= '0;
      rsum_r    <= '0;
      rd_pend_r <= 1'b0;
      verr_r    <= 1'b0;
    end else begin
      rd_pend_r <= vrd_s;
      if (ag_load_s) begin
        wsum_r <= '0;
        rsum_r <= '0;
        verr_r <= 1'b0;
      end else begin
        if (fill_wr_s) begin
          wsum_r <= wsum_r + {{AWID{1'b0}}, bus.ri_data};
        end
        if (rd_pend_r) begin
          rsum_r <= rsum_r + {{AWID{1'b0}}, bus.ram_dout};
        end
        if (cmp_s) begin
          verr_r <= (wsum_r != (rsum_r + {{AWID{1'b0}}, bus.ram_dout}));
        end
      end
    end
  end

  assign bus.verify_err = verr_r;
`endif

endmodule

// File: tb/tb_bram_reinit_ctrl.sv
// Scoreboard bench for bram_reinit_ctrl with a behavioural 1-cycle-read RAM.
// Read-back checksum checks are active when BRAM_REINIT_VERIFY_EN is defined.
module tb_bram_reinit_ctrl;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   beats_seen = 0;
  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  int         done_q[$];
  logic [7:0] mem [0:4095];
  logic [7:0] dout_r;
  logic [7:0] corrupt;

  bram_reinit_ctrl_if #(.DWID(8), .AWID(12)) bus ();

  bram_reinit_ctrl #(.DWID(8), .AWID(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, read-during-write returns old data
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
    dout_r <= mem[bus.ram_addr];
  end
  assign bus.ram_dout = dout_r ^ corrupt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RAM write, user read return and done pulse is matched against the queues
  always @(negedge clk) begin
    if (rst) begin
      beats_seen = 0;
    end else begin
      if (bus.ri_start && !bus.busy) beats_seen = 0;
      if (bus.ram_wen) begin
        if (bus.busy) beats_seen++;
        if (wr_q.size() == 0) begin
          check("unexpected_write", {bus.ram_addr, bus.ram_din}, 32'hFFFFFFFF);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", bus.ram_addr, w.a);
          check("wr_data", bus.ram_din, w.d);
        end
      end
      if (bus.u_rvalid) begin
        if (rd_q.size() == 0) check("unexpected_rvalid", bus.u_dout, 32'hFFFFFFFF);
        else check("u_dout", bus.u_dout, rd_q.pop_front());
      end
      if (bus.done) begin
        if (done_q.size() == 0) check("unexpected_done", beats_seen, 32'hFFFFFFFF);
        else check("done_beats", beats_seen, done_q.pop_front());
      end
    end
  end

  task automatic user_read(input logic [11:0] a, input logic [7:0] exp);
    tick();
    bus.u_req = 1'b1; bus.u_wen = 1'b0; bus.u_addr = a;
    rd_q.push_back(exp);
    @(negedge clk);
    check("rd_gnt", bus.u_gnt, 1'b1);
    tick();
    bus.u_req = 1'b0;
    @(negedge clk);
    check("rd_rvalid", bus.u_rvalid, 1'b1);
  endtask

  task automatic reinit(input logic [11:0] base, input logic [11:0] len, input logic [7:0] seed,
                        input logic [7:0] step, input int gap_after, input bit hold,
                        input logic exp_verr);
    int nb;
    int k;
    logic [7:0] ib;
    logic [7:0] d;
    nb = (len == 12'd0) ? 4096 : int'(len);
    tick();
    if (hold) begin
      bus.u_req = 1'b1; bus.u_wen = 1'b0; bus.u_addr = base;
    end
    bus.ri_start = 1'b1; bus.ri_base = base; bus.ri_len = len;
    @(negedge clk);
    check("ready_in_idle", bus.ri_ready, 1'b0);
    if (hold) check("gnt_vs_start", bus.u_gnt, 1'b0);
    for (int i = 0; i < nb; i++) begin
      tick();
      bus.ri_start = 1'b0;
      ib = i[7:0];
      d  = seed + step * ib;
      bus.ri_valid = 1'b1; bus.ri_data = d;
      wr_q.push_back({base + i[11:0], d});
      if (i == nb - 1) done_q.push_back(nb);
      if (i == 0) begin
        @(negedge clk);
        check("fill_ready", bus.ri_ready, 1'b1);
        check("fill_busy", bus.busy, 1'b1);
        if (hold) check("fill_gnt", bus.u_gnt, 1'b0);
      end
      if (i == gap_after) begin
        tick();
        bus.ri_valid = 1'b0;
        @(negedge clk);
        check("stall_ready", bus.ri_ready, 1'b1);
        tick();
      end
    end
    tick();
    bus.ri_valid = 1'b0; bus.ri_data = 8'h00;
    k = 0;
    @(negedge clk);
    while (!bus.done && k < nb + 8) begin
      k++;
      tick();
      @(negedge clk);
    end
    check("done_seen", bus.done, 1'b1);
    check("done_busy", bus.busy, 1'b1);
`ifdef BRAM_REINIT_VERIFY_EN
    check("verify_cycles", k, nb + 1);
    check("verify_err", bus.verify_err, exp_verr);
`else
    check("done_latency", k, 0);
    check("verr_unused", exp_verr, 1'b0);
`endif
    if (hold) check("done_gnt", bus.u_gnt, 1'b0);
    tick();
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_done", bus.done, 1'b0);
    if (hold) begin
      check("post_done_gnt", bus.u_gnt, 1'b1);
      rd_q.push_back(seed);
      tick();
      bus.u_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.u_req = 1'b0; bus.u_wen = 1'b0; bus.u_addr = 12'h000; bus.u_din = 8'h00;
    bus.ri_start = 1'b0; bus.ri_base = 12'h000; bus.ri_len = 12'h000;
    bus.ri_valid = 1'b0; bus.ri_data = 8'h00; bus.ri_abort = 1'b0;
    corrupt = 8'h00;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ready", bus.ri_ready, 1'b0);
    check("rst_rvalid", bus.u_rvalid, 1'b0);
    check("rst_wen", bus.ram_wen, 1'b0);
`ifdef BRAM_REINIT_VERIFY_EN
    check("rst_verr", bus.verify_err, 1'b0);
`endif

    // idle user write then read
    tick();
    bus.u_req = 1'b1; bus.u_wen = 1'b1; bus.u_addr = 12'h010; bus.u_din = 8'hA5;
    wr_q.push_back({12'h010, 8'hA5});
    @(negedge clk);
    check("wr_gnt", bus.u_gnt, 1'b1);
    tick();
    bus.u_wen = 1'b0;
    rd_q.push_back(8'hA5);
    @(negedge clk);
    check("rd_gnt0", bus.u_gnt, 1'b1);
    tick();
    bus.u_req = 1'b0;
    @(negedge clk);
    check("rvalid_lat", bus.u_rvalid, 1'b1);

    // basic window with a 2-cycle stall, then read back
    reinit(12'h000, 12'd4, 8'h11, 8'h11, 1, 1'b0, 1'b0);
    user_read(12'h000, 8'h11);
    user_read(12'h001, 8'h22);
    user_read(12'h002, 8'h33);
    user_read(12'h003, 8'h44);

    // wrap past the top address, and full 4096-word window
    reinit(12'hFFE, 12'd3, 8'hC0, 8'h01, -1, 1'b0, 1'b0);
    user_read(12'h000, 8'hC2);
    reinit(12'h123, 12'd0, 8'h00, 8'h01, -1, 1'b0, 1'b0);
    user_read(12'h122, 8'hFF);

    // user request held across start, fill and done
    reinit(12'h002, 12'd2, 8'h70, 8'h01, -1, 1'b1, 1'b0);

    // abort after 2 of 8 beats
    tick();
    bus.ri_start = 1'b1; bus.ri_base = 12'h040; bus.ri_len = 12'd8;
    tick();
    bus.ri_start = 1'b0; bus.ri_valid = 1'b1; bus.ri_data = 8'h80;
    wr_q.push_back({12'h040, 8'h80});
    tick();
    bus.ri_data = 8'h81;
    wr_q.push_back({12'h041, 8'h81});
    tick();
    bus.ri_data = 8'hEE; bus.ri_abort = 1'b1;
    @(negedge clk);
    check("abort_ready", bus.ri_ready, 1'b0);
    check("abort_wen", bus.ram_wen, 1'b0);
    tick();
    bus.ri_abort = 1'b0; bus.ri_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    user_read(12'h041, 8'h81);

    // synchronous reset in the middle of a fill
    tick();
    bus.u_addr = 12'h000; bus.u_din = 8'h00;
    bus.ri_start = 1'b1; bus.ri_base = 12'h080; bus.ri_len = 12'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.ri_start = 1'b0; bus.ri_valid = 1'b1; bus.ri_data = 8'h90 + i[7:0];
      wr_q.push_back({12'h080 + i[11:0], 8'h90 + i[7:0]});
    end
    tick();
    rst = 1'b1; bus.ri_data = 8'hDD;
    @(negedge clk);
    check("rst_cycle_wen", bus.ram_wen, 1'b0);
    tick();
    rst = 1'b0; bus.ri_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_ready", bus.ri_ready, 1'b0);
    check("mid_rst_gnt", bus.u_gnt, 1'b0);
    check("mid_rst_rvalid", bus.u_rvalid, 1'b0);
    check("mid_rst_dout", bus.u_dout, 8'h00);
    check("mid_rst_wen", bus.ram_wen, 1'b0);
    check("mid_rst_addr", bus.ram_addr, 12'h000);

`ifdef BRAM_REINIT_VERIFY_EN
    // corrupted read-back data must flag a checksum mismatch, held until next start
    corrupt = 8'h40;
    reinit(12'h200, 12'd4, 8'h30, 8'h01, -1, 1'b0, 1'b1);
    corrupt = 8'h00;
    tick();
    @(negedge clk);
    check("verr_held", bus.verify_err, 1'b1);
    reinit(12'h300, 12'd4, 8'h50, 8'h03, 2, 1'b0, 1'b0);
`endif

    repeat (3) tick();
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
